fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage for the pipelined successor of the single-cycle RISC-V core. Owns the PC and issues sequential word fetches over a valid/ready instruction-memory port that tolerates multi-cycle latency. Buffers returned instructions in a small FIFO and hands {pc, instr, pc+4} to decode with a valid/ready handshake. Accepts a redirect from the branch/jump resolution logic and discards all stale in-flight and buffered work.

## Interface
- XLEN, 32, address/PC width; instructions are always 32 bit
- RESET_PC, 0, PC fetched first after reset; bits [1:0] must be 0
- FIFO_DEPTH, 4, instruction buffer entries; power of two, at least 2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word-aligned fetch address
- imem_rsp_valid  in  1  response valid; in order, one per accepted request, no earlier than the cycle after acceptance, no backpressure
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  control-flow redirect, single-cycle pulse allowed
- redirect_pc  in  XLEN  redirect target; bits [1:0] forced to 0
- if_valid  out  1  decode entry valid
- if_ready  in  1  decode accepts entry
- if_pc  out  XLEN  PC of presented instruction
- if_instr  out  32  presented instruction
- if_pc_plus4  out  XLEN  if_pc + 4, modulo 2^XLEN

## Operation
- State: fetch_pc (next request address), out_pc (PC of FIFO head), FIFO occupancy, live outstanding count, discard count. Counter widths: clog2(FIFO_DEPTH)+1.
- Issue: imem_req_valid = (occupancy + live_outstanding < FIFO_DEPTH), using registered values. This credit check guarantees FIFO space for every live response.
- Request fire (valid & ready): fetch_pc += 4, live_outstanding += 1. imem_req_addr = fetch_pc. Once raised, valid stays high with a stable address until it fires, except across a redirect.
- Response: if discard > 0, drop it and decrement discard. Otherwise enqueue imem_rsp_data and decrement live_outstanding.
- Dequeue (if_valid & if_ready): pop the FIFO head; out_pc += 4. if_valid = FIFO non-empty & !redirect_valid.
- Redirect cycle:
  - fetch_pc and out_pc are set to the aligned redirect_pc.
  - FIFO is cleared.
  - discard = discard + live_outstanding + req_fire − live_rsp_this_cycle, so every request still in flight after the cycle is dropped. This includes a request fired in the redirect cycle.
  - live_outstanding is set to 0.
  - A response arriving in the redirect cycle is never enqueued.
  - No dequeue takes effect.
- Simultaneous enqueue and dequeue: occupancy unchanged.
- Simultaneous request fire and response: outstanding unchanged.
- PC arithmetic wraps modulo 2^XLEN, e.g. 0xFFFF_FFFC + 4 = 0.

## Timing
- Reset values:
  - imem_req_valid=0, imem_req_addr=RESET_PC.
  - if_valid=0, if_pc=RESET_PC, if_pc_plus4=RESET_PC+4, if_instr=0.
  - All counters 0.
- First request is in the first cycle after rst deasserts.
- Latency: with a 1-cycle memory, a request accepted in cycle N returns in N+1 and is presented on if_* in N+2. There is no FIFO bypass.
- Throughput: FIFO_DEPTH=4 sustains one instruction per cycle with 1-cycle memory and if_ready held high.
- Redirect to first new instruction (1-cycle memory, no stale responses): request in R+1, if_valid in R+3.
- rst asserted mid-operation clears all state immediately. Responses to pre-reset requests must not be delivered after reset; the memory is reset together with this block.

## Configuration
- FETCH_PERF_EN defined: adds output ports perf_fetched (32 bit, counts dequeues) and perf_discarded (32 bit, counts dropped responses plus FIFO entries flushed by redirect). Both reset to 0 and wrap on overflow.
- FETCH_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package riscv_pkg holds:
  - XLEN default
  - RESET_PC default
  - INSTR_W=32
  - PC_INC=4
  - NOP encoding 32'h0000_0013, used by decode for bubbles
- One sub-module: sync_fifo, parametrised by width and depth. It has synchronous clear and asynchronous reset, and exposes occupancy. It stores instructions only; PCs are reconstructed from out_pc.
- Credit, discard and PC logic stay in fetch_unit.

## Test plan
- Reset release, 1-cycle memory, if_ready=1 → requests at 0x0, 0x4, 0x8…; if_valid from cycle 2; if_pc 0x0, 0x4, 0x8 with matching instructions back-to-back.
- if_ready=0 for 10 cycles → exactly FIFO_DEPTH requests accepted, then imem_req_valid=0; release → 4 entries drained in order with no loss.
- 3-cycle memory latency, 2 requests outstanding, redirect_pc=0x100 → both stale responses dropped; next if_pc=0x100 with the 0x100 instruction.
- Redirect in the same cycle a request fires and a response arrives → neither the response nor the reply to that request appears on if_*; the FIFO is empty the next cycle.
- RESET_PC=0xFFFF_FFF8 → if_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; redirect_pc=0x203 → fetch at 0x200.
- FETCH_PERF_EN defined, the scenario-3 sequence → perf_discarded=2 and perf_fetched equal to the handshake count.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants for the pipelined RISC-V core: default widths, PC step and the bubble NOP.
package riscv_pkg;
  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned INSTR_W          = 32;
  localparam int unsigned PC_INC           = 4;
  localparam logic [31:0] NOP              = 32'h0000_0013;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect input and decode-side handshake.
interface fetch_unit_if
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
);
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [XLEN-1:0]    imem_req_addr;
  logic               imem_rsp_valid;
  logic [INSTR_W-1:0] imem_rsp_data;
  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               if_valid;
  logic               if_ready;
  logic [XLEN-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr;
  logic [XLEN-1:0]    if_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output if_valid, if_pc, if_instr, if_pc_plus4,
    input  if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  if_valid, if_pc, if_instr, if_pc_plus4,
    output if_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with async reset, sync clear (priority over push/pop) and occupancy output.
module sync_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH = INSTR_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign empty   = (count_q == '0);
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited sequential fetch, instruction FIFO, redirect with stale discard.
// Optional FETCH_PERF_EN adds perf_fetched / perf_discarded counters.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN       = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_discarded
`endif
);
  localparam int unsigned     CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_C = (CW+1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] INC     = XLEN'(PC_INC);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, out_pc_q, out_pc_d, target_pc;
  logic [CW-1:0]   live_q, live_d, discard_q, discard_d, occ;
  logic [CW:0]     credit_used;
  logic            fifo_empty, req_fire, rsp_live, rsp_drop, enq, deq;

  assign target_pc   = bus.redirect_pc & ~XLEN'(3);
  assign credit_used = {1'b0, occ} + {1'b0, live_q};

  // Gated by rst so the request stays low while reset is held.
  assign bus.imem_req_valid = ~rst & (credit_used < DEPTH_C);
  assign bus.imem_req_addr  = fetch_pc_q;
  assign req_fire           = bus.imem_req_valid & bus.imem_req_ready;

  assign rsp_drop = bus.imem_rsp_valid & (discard_q != '0);
  assign rsp_live = bus.imem_rsp_valid & (discard_q == '0);
  assign enq      = rsp_live & ~bus.redirect_valid;

  assign bus.if_valid    = ~fifo_empty & ~bus.redirect_valid;
  assign deq             = bus.if_valid & bus.if_ready;
  assign bus.if_pc       = out_pc_q;
  assign bus.if_pc_plus4 = out_pc_q + INC;

  always_comb begin
    fetch_pc_d = fetch_pc_q + (req_fire ? INC : '0);
    out_pc_d   = out_pc_q + (deq ? INC : '0);
    live_d     = live_q + CW'(req_fire) - CW'(rsp_live);
    discard_d  = discard_q - CW'(rsp_drop);
    if (bus.redirect_valid) begin
      fetch_pc_d = target_pc;
      out_pc_d   = target_pc;
      // Everything still in flight after this cycle becomes stale, including a request fired now.
      discard_d  = discard_q - CW'(rsp_drop) + live_q + CW'(req_fire) - CW'(rsp_live);
      live_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      out_pc_q   <= RESET_PC;
      live_q     <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      out_pc_q   <= out_pc_d;
      live_q     <= live_d;
      discard_q  <= discard_d;
    end
  end

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (bus.redirect_valid),
    .wr_en   (enq),
    .wr_data (bus.imem_rsp_data),
    .rd_en   (deq),
    .rd_data (bus.if_instr),
    .count   (occ),
    .empty   (fifo_empty)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d, discarded_q, discarded_d;

  always_comb begin
    fetched_d   = fetched_q + 32'(deq);
    discarded_d = discarded_q + 32'(rsp_drop)
                + (bus.redirect_valid ? (32'(occ) + 32'(rsp_live)) : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q   <= '0;
      discarded_q <= '0;
    end else begin
      fetched_q   <= fetched_d;
      discarded_q <= discarded_d;
    end
  end

  assign perf_fetched   = fetched_q;
  assign perf_discarded = discarded_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: reset values, vector table, redirect corner sequences, randomized traffic vs stream model.
module tb_fetch_unit;
  import riscv_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) bus  ();
  fetch_unit_if #(.XLEN(32)) bus1 ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_discarded, perf_fetched1, perf_discarded1;
`endif

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_EN
    , .perf_fetched (perf_fetched), .perf_discarded (perf_discarded)
`endif
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
`ifdef FETCH_PERF_EN
    , .perf_fetched (perf_fetched1), .perf_discarded (perf_discarded1)
`endif
  );

  typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
  typedef struct { logic rr; logic ir; logic ev; logic [31:0] ea; logic iv; logic [31:0] ip; } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  mreq_t       mq[$];
  int          lat_min  = 1;
  int          lat_max  = 1;
  int          last_due = 0;
  int          epoch    = 0;
  int          cur_epoch = -1;
  int          ep_fires, ep_rsps, ep_deq, n_deq, n1;
  logic [31:0] exp_req_addr, exp_if_pc, exp1_pc, rsp1_addr;
  logic        rsp1_pend;
  vec_t        tbl[18];

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: within an epoch (since reset/redirect) fetches and deliveries are consecutive PCs,
  // credits in use = fires - dequeues, buffered = live responses - dequeues.
  task automatic sample_and_check();
    logic  fire, deq, exp_rv, exp_iv;
    int    due;
    fire   = bus.imem_req_valid & bus.imem_req_ready;
    deq    = bus.if_valid & bus.if_ready;
    exp_rv = (ep_fires - ep_deq) < int'(DEPTH);
    exp_iv = (ep_rsps > ep_deq) && !bus.redirect_valid;
    check("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    check("req_addr", bus.imem_req_addr, exp_req_addr);
    check("if_valid", 32'(bus.if_valid), 32'(exp_iv));
    if (bus.if_valid) begin
      check("if_pc", bus.if_pc, exp_if_pc);
      check("if_instr", bus.if_instr, instr_of(exp_if_pc));
      check("if_pc_plus4", bus.if_pc_plus4, exp_if_pc + 32'd4);
    end
    if (fire) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{bus.imem_req_addr, due, epoch});
      ep_fires++;
      exp_req_addr += 32'd4;
    end
    if (bus.imem_rsp_valid && cur_epoch == epoch) ep_rsps++;
    if (deq) begin
      ep_deq++;
      n_deq++;
      exp_if_pc += 32'd4;
    end
    if (bus.redirect_valid) begin
      epoch++;
      ep_fires = 0;
      ep_rsps  = 0;
      ep_deq   = 0;
      exp_req_addr = bus.redirect_pc & ~32'h3;
      exp_if_pc    = bus.redirect_pc & ~32'h3;
    end
    if (bus1.if_valid) begin
      check("wrap_if_pc", bus1.if_pc, exp1_pc);
      check("wrap_if_instr", bus1.if_instr, instr_of(exp1_pc));
      check("wrap_if_pc_plus4", bus1.if_pc_plus4, exp1_pc + 32'd4);
      exp1_pc += 32'd4;
      n1++;
    end
    if (bus1.imem_req_valid) begin
      rsp1_pend = 1'b1;
      rsp1_addr = bus1.imem_req_addr;
    end
  endtask

  task automatic post_edge();
    mreq_t r;
    bus.redirect_valid = 1'b0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      r = mq.pop_front();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = instr_of(r.addr);
      cur_epoch          = r.epoch;
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
      cur_epoch          = -1;
    end
    bus1.imem_rsp_valid = rsp1_pend;
    bus1.imem_rsp_data  = instr_of(rsp1_addr);
    rsp1_pend           = 1'b0;
  endtask

  task automatic finish_cycle();
    sample_and_check();
    @(posedge clk);
    cyc++;
    #1;
    post_edge();
  endtask

  task automatic step();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.imem_rsp_valid  = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus1.imem_rsp_valid = 1'b0;
    rsp1_pend = 1'b0;
    mq.delete();
    #1;
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_req_addr", bus.imem_req_addr, 32'h0);
    check("rst_if_valid", 32'(bus.if_valid), 32'd0);
    check("rst_if_pc", bus.if_pc, 32'h0);
    check("rst_if_pc_plus4", bus.if_pc_plus4, 32'h4);
    check("rst_if_instr", bus.if_instr, 32'h0);
    check("rst_wrap_if_pc", bus1.if_pc, 32'hFFFF_FFF8);
    check("rst_wrap_req_addr", bus1.imem_req_addr, 32'hFFFF_FFF8);
    check("rst_wrap_if_pc_plus4", bus1.if_pc_plus4, 32'hFFFF_FFFC);
`ifdef FETCH_PERF_EN
    check("rst_perf_fetched", perf_fetched, 32'h0);
    check("rst_perf_discarded", perf_discarded, 32'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0; last_due = 0; cur_epoch = -1;
    epoch++; ep_fires = 0; ep_rsps = 0; ep_deq = 0; n_deq = 0;
    exp_req_addr = 32'h0; exp_if_pc = 32'h0; exp1_pc = 32'hFFFF_FFF8;
  endtask

  initial begin
    bit found;
    bus.imem_req_ready = 1'b0; bus.if_ready = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus1.imem_req_ready = 1'b1; bus1.if_ready = 1'b1;
    bus1.redirect_valid = 1'b0; bus1.redirect_pc = '0;
    bus1.imem_rsp_valid = 1'b0; bus1.imem_rsp_data = '0;
    rsp1_addr = '0; n1 = 0;

    // 1-cycle memory from reset release: streaming, then a 7-cycle decode stall, then drain.
    tbl[0]  = '{1, 1, 1, 32'h00, 0, 32'h00};
    tbl[1]  = '{1, 1, 1, 32'h04, 0, 32'h00};
    tbl[2]  = '{1, 1, 1, 32'h08, 1, 32'h00};
    tbl[3]  = '{1, 1, 1, 32'h0C, 1, 32'h04};
    tbl[4]  = '{1, 1, 1, 32'h10, 1, 32'h08};
    tbl[5]  = '{1, 0, 1, 32'h14, 1, 32'h0C};
    tbl[6]  = '{1, 0, 1, 32'h18, 1, 32'h0C};
    tbl[7]  = '{1, 0, 0, 32'h1C, 1, 32'h0C};
    tbl[8]  = '{1, 0, 0, 32'h1C, 1, 32'h0C};
    tbl[9]  = '{1, 0, 0, 32'h1C, 1, 32'h0C};
    tbl[10] = '{1, 0, 0, 32'h1C, 1, 32'h0C};
    tbl[11] = '{1, 0, 0, 32'h1C, 1, 32'h0C};
    tbl[12] = '{1, 1, 0, 32'h1C, 1, 32'h0C};
    tbl[13] = '{1, 1, 1, 32'h1C, 1, 32'h10};
    tbl[14] = '{1, 1, 1, 32'h20, 1, 32'h14};
    tbl[15] = '{1, 1, 1, 32'h24, 1, 32'h18};
    tbl[16] = '{1, 1, 1, 32'h28, 1, 32'h1C};
    tbl[17] = '{1, 1, 1, 32'h2C, 1, 32'h20};

    #3;
    apply_reset();
    lat_min = 1; lat_max = 1;
    foreach (tbl[i]) begin
      bus.imem_req_ready = tbl[i].rr;
      bus.if_ready       = tbl[i].ir;
      @(negedge clk);
      check($sformatf("tbl%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(tbl[i].ev));
      check($sformatf("tbl%0d_req_addr", i), bus.imem_req_addr, tbl[i].ea);
      check($sformatf("tbl%0d_if_valid", i), 32'(bus.if_valid), 32'(tbl[i].iv));
      if (tbl[i].iv) begin
        check($sformatf("tbl%0d_if_pc", i), bus.if_pc, tbl[i].ip);
        check($sformatf("tbl%0d_if_instr", i), bus.if_instr, instr_of(tbl[i].ip));
      end
      finish_cycle();
    end

    // 3-cycle memory, two requests in flight, redirect to 0x100.
    apply_reset();
    lat_min = 3; lat_max = 3;
    bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1;
    step();
    step();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    step();
    bus.imem_req_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (bus.if_valid) begin
        found = 1'b1;
        check("s3_if_pc", bus.if_pc, 32'h100);
        check("s3_if_instr", bus.if_instr, instr_of(32'h100));
`ifdef FETCH_PERF_EN
        check("s3_perf_discarded", perf_discarded, 32'd2);
        check("s3_perf_fetched", perf_fetched, 32'(n_deq));
`endif
      end
      finish_cycle();
    end
    check("s3_delivered", 32'(found), 32'd1);

    // Redirect in a cycle with a request fire and a response arrival; unaligned target.
    apply_reset();
    lat_min = 1; lat_max = 1;
    bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1;
    step();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h203;
    @(negedge clk);
    check("s4_fire_in_redirect", 32'(bus.imem_req_valid), 32'd1);
    check("s4_if_valid_r", 32'(bus.if_valid), 32'd0);
    finish_cycle();
    @(negedge clk);
    check("s4_fifo_empty_r1", 32'(bus.if_valid), 32'd0);
    check("s4_req_valid_r1", 32'(bus.imem_req_valid), 32'd1);
    check("s4_req_addr_r1", bus.imem_req_addr, 32'h200);
    finish_cycle();
    @(negedge clk);
    check("s4_if_valid_r2", 32'(bus.if_valid), 32'd0);
    finish_cycle();
    @(negedge clk);
    check("s4_if_valid_r3", 32'(bus.if_valid), 32'd1);
    check("s4_if_pc_r3", bus.if_pc, 32'h200);
    check("s4_if_instr_r3", bus.if_instr, instr_of(32'h200));
    finish_cycle();

    // Randomized traffic with variable latency, backpressure, redirects and one mid-run reset.
    apply_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) apply_reset();
      bus.imem_req_ready = ($urandom_range(3, 0) != 0);
      bus.if_ready       = ($urandom_range(9, 0) < 7);
      if (mq.size() <= 5 && $urandom_range(24, 0) == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      end
      step();
    end
    bus.redirect_valid = 1'b0;
    @(negedge clk);
`ifdef FETCH_PERF_EN
    check("rand_perf_fetched", perf_fetched, 32'(n_deq));
`endif
    check("wrap_delivered", 32'(n1 >= 3), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
